pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-write EIP register.
- Holds the current instruction pointer and advances it by the decoded instruction length.
- Handles jump, call and return, with an internal return-address stack (RAS).
- Sits between decode/execute control and the fetch stage; `pc` drives the fetch address directly.

---
 rtl/pc_pkg.sv | 16 +
 rtl/ras_stack.sv | 67 ++++++
 rtl/pc_unit.sv | 87 ++++++++
 tb/tb_pc_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Program-counter unit shared definitions: op codes and default reset vector.
// Optional build macro used by this slice: PC_RAS_WRAP_EN (see ras_stack).
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_HOLD  = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_OP_SEQ   = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_OP_JMP   = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL  = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_OP_RET   = 3'd4;
  localparam logic [PC_OP_W-1:0] PC_OP_FLUSH = 3'd5;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack, LIFO, DEPTH entries of W bits.
// Build macro PC_RAS_WRAP_EN: when defined the stack is a circular buffer that
// overwrites its oldest entry on a push while full; otherwise such a push is
// discarded and reported on 'dropped'.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       dropped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             do_write;

  // Write pointer runs modulo DEPTH in both modes, so the top entry is always
  // the one just below it; without wrap the pointer simply never laps.
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign depth   = count;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);

`ifdef PC_RAS_WRAP_EN
  assign do_write = push;
  assign dropped  = 1'b0;
`else
  assign do_write = push && !full;
  assign dropped  = push && full;
`endif

  // Pointer and occupancy; a push while full (wrap mode) keeps count saturated.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC mux, RET fault and RAS overflow
// flags. The return-address stack lives in ras_stack; build macro
// PC_RAS_WRAP_EN selects its full-stack policy.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned        RAS_DEPTH = 8,
  parameter int unsigned        LEN_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [PC_OP_W-1:0]             op,
  input  logic [LEN_W-1:0]               inst_len,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ret_fault,
  output logic                           ras_ovf
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] pc_next;
  logic              do_call;
  logic              do_ret;
  logic              do_flush;
  logic              ras_dropped;

  assign seq_pc   = pc + ADDR_W'(inst_len);
  assign do_call  = !stall && (op == PC_OP_CALL);
  assign do_ret   = !stall && (op == PC_OP_RET);
  assign do_flush = !stall && (op == PC_OP_FLUSH);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_call),
    .pop       (do_ret),
    .flush     (do_flush),
    .push_data (seq_pc),
    .top       (ras_top),
    .depth     (ras_depth),
    .empty     (ras_empty),
    .full      (ras_full),
    .dropped   (ras_dropped)
  );

  // Next-PC selection; reserved codes fall through to hold.
  always_comb begin
    pc_next = pc;
    case (op)
      PC_OP_SEQ:   pc_next = seq_pc;
      PC_OP_JMP,
      PC_OP_CALL,
      PC_OP_FLUSH: pc_next = target;
      PC_OP_RET:   if (!ras_empty) pc_next = ras_top;
      default:     pc_next = pc;
    endcase
  end

  // PC register: reset wins, stall freezes.
  always_ff @(posedge clk) begin
    if (reset)       pc <= RESET_VEC;
    else if (!stall) pc <= pc_next;
  end

  // One-cycle pulse for a RET that found the stack empty.
  always_ff @(posedge clk) begin
    if (reset) ret_fault <= 1'b0;
    else       ret_fault <= do_ret && ras_empty;
  end

  // Sticky record of a dropped return address, cleared by FLUSH.
  always_ff @(posedge clk) begin
    if (reset || do_flush) ras_ovf <= 1'b0;
    else if (ras_dropped)  ras_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned DW        = $clog2(RAS_DEPTH+1);
  localparam logic [31:0] RST_VEC   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic [2:0]        op;
  logic [LEN_W-1:0]  inst_len;
  logic [31:0]       target;
  logic [31:0]       pc;
  logic [DW-1:0]     ras_depth;
  logic              ras_empty;
  logic              ras_full;
  logic              ret_fault;
  logic              ras_ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_fault;
  logic        m_ovf;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RST_VEC),
    .RAS_DEPTH (RAS_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .op        (op),
    .inst_len  (inst_len),
    .target    (target),
    .pc        (pc),
    .ras_depth (ras_depth),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ret_fault (ret_fault),
    .ras_ovf   (ras_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic [2:0] o,
                       input logic [LEN_W-1:0] l, input logic [31:0] t);
    logic [31:0] ra;
    ra = m_pc + 32'(l);
    if (r) begin
      m_pc = RST_VEC;
      m_ras.delete();
      m_fault = 1'b0;
      m_ovf = 1'b0;
    end else if (s) begin
      m_fault = 1'b0;
    end else begin
      m_fault = 1'b0;
      case (o)
        3'd1: m_pc = ra;
        3'd2: m_pc = t;
        3'd3: begin
          if (m_ras.size() < RAS_DEPTH) m_ras.push_back(ra);
          else begin
`ifdef PC_RAS_WRAP_EN
            void'(m_ras.pop_front());
            m_ras.push_back(ra);
`else
            m_ovf = 1'b1;
`endif
          end
          m_pc = t;
        end
        3'd4: begin
          if (m_ras.size() == 0) m_fault = 1'b1;
          else m_pc = m_ras.pop_back();
        end
        3'd5: begin
          m_pc = t;
          m_ras.delete();
          m_ovf = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [LEN_W-1:0] l, input logic [31:0] t);
    reset = r; stall = s; op = o; inst_len = l; target = t;
    @(posedge clk);
    #1;
    model(r, s, o, l, t);
    chk("pc",        pc,                m_pc);
    chk("ras_depth", 32'(ras_depth),    32'(m_ras.size()));
    chk("ras_empty", 32'(ras_empty),    32'(m_ras.size() == 0));
    chk("ras_full",  32'(ras_full),     32'(m_ras.size() == RAS_DEPTH));
    chk("ret_fault", 32'(ret_fault),    32'(m_fault));
    chk("ras_ovf",   32'(ras_ovf),      32'(m_ovf));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rtgt;
    logic [31:0] exp_ret;

    // Reset and idle
    m_pc = '0; m_fault = 1'b0; m_ovf = 1'b0;
    step(1'b1, 1'b0, PC_OP_JMP, 4'd0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, PC_OP_HOLD, 4'd7, 32'h0);
    chk("rst_pc",    pc,              32'h0);
    chk("rst_empty", 32'(ras_empty),  32'd1);
    chk("rst_fault", 32'(ret_fault),  32'd0);
    chk("rst_ovf",   32'(ras_ovf),    32'd0);

    // Sequential advance and wrap
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'h100);
    step(1'b0, 1'b0, PC_OP_SEQ, 4'd3, 32'h0);  chk("seq3",  pc, 32'h103);
    step(1'b0, 1'b0, PC_OP_SEQ, 4'd5, 32'h0);  chk("seq5",  pc, 32'h108);
    step(1'b0, 1'b0, PC_OP_SEQ, 4'd15, 32'h0); chk("seq15", pc, 32'h117);
    step(1'b0, 1'b0, PC_OP_SEQ, 4'd0, 32'h0);  chk("seq0",  pc, 32'h117);
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, PC_OP_SEQ, 4'd2, 32'h0);  chk("seqwrap", pc, 32'h1);

    // Nested call / return
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'h200);
    step(1'b0, 1'b0, PC_OP_CALL, 4'd5, 32'h4000);
    chk("call1_pc", pc, 32'h4000); chk("call1_d", 32'(ras_depth), 32'd1);
    step(1'b0, 1'b0, PC_OP_CALL, 4'd2, 32'h5000);
    chk("call2_pc", pc, 32'h5000); chk("call2_d", 32'(ras_depth), 32'd2);
    step(1'b0, 1'b0, PC_OP_RET, 4'd0, 32'h0);
    chk("ret1_pc", pc, 32'h4002); chk("ret1_d", 32'(ras_depth), 32'd1);
    step(1'b0, 1'b0, PC_OP_RET, 4'd0, 32'h0);
    chk("ret2_pc", pc, 32'h205); chk("ret2_d", 32'(ras_depth), 32'd0);

    // RET on empty stack
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'h300);
    step(1'b0, 1'b0, PC_OP_RET, 4'd0, 32'h0);
    chk("eret_pc", pc, 32'h300); chk("eret_fault", 32'(ret_fault), 32'd1);
    chk("eret_d", 32'(ras_depth), 32'd0);
    step(1'b0, 1'b0, PC_OP_HOLD, 4'd0, 32'h0);
    chk("eret_pulse", 32'(ret_fault), 32'd0);

    // Overflow: call i issued at pc 0x10000*i with length 4
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'h10000);
    for (int i = 1; i <= 9; i++)
      step(1'b0, 1'b0, PC_OP_CALL, 4'd4, 32'(i + 1) << 16);
`ifdef PC_RAS_WRAP_EN
    chk("ovf9", 32'(ras_ovf), 32'd0);
`else
    chk("ovf9", 32'(ras_ovf), 32'd1);
`endif
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 1'b0, PC_OP_RET, 4'd0, 32'h0);
`ifdef PC_RAS_WRAP_EN
      exp_ret = (32'(10 - j) << 16) + 32'd4;
`else
      exp_ret = (32'(9 - j) << 16) + 32'd4;
`endif
      chk("ovf_ret", pc, exp_ret);
    end
    step(1'b0, 1'b0, PC_OP_RET, 4'd0, 32'h0);
    chk("ovf_ret9_fault", 32'(ret_fault), 32'd1);

    // FLUSH clears overflow; stall freezes a pending CALL
    step(1'b0, 1'b0, PC_OP_FLUSH, 4'd0, 32'h800);
    chk("flush_ovf", 32'(ras_ovf), 32'd0);
    step(1'b0, 1'b0, PC_OP_CALL, 4'd1, 32'h900);
    step(1'b0, 1'b1, PC_OP_CALL, 4'd1, 32'hA00);
    step(1'b0, 1'b1, PC_OP_CALL, 4'd1, 32'hA00);
    chk("stall_pc", pc, 32'h900); chk("stall_d", 32'(ras_depth), 32'd1);
    step(1'b0, 1'b0, PC_OP_CALL, 4'd1, 32'hA00);
    chk("unstall_pc", pc, 32'hA00);
    step(1'b0, 1'b0, PC_OP_CALL, 4'd1, 32'hB00);
    chk("pre_flush_d", 32'(ras_depth), 32'd3);
    step(1'b0, 1'b0, PC_OP_FLUSH, 4'd0, 32'h1000);
    chk("flush_pc", pc, 32'h1000); chk("flush_d", 32'(ras_depth), 32'd0);

    // Reset beats JMP
    step(1'b0, 1'b0, PC_OP_JMP, 4'd0, 32'h7777);
    step(1'b1, 1'b0, PC_OP_JMP, 4'd0, 32'hDEAD_BEEF);
    chk("rst_jmp", pc, RST_VEC);

    // Random traffic, biased toward CALL/RET so the stack fills and drains
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rop = PC_OP_CALL;
        3, 4, 5: rop = PC_OP_RET;
        default: rop = 3'($urandom_range(0, 7));
      endcase
      rtgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), rop,
           LEN_W'($urandom_range(0, 15)), rtgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
